// File: rtl/ofifo_drain_ctrl.sv
// Drains the column-parallel output FIFO into the psum SRAM after each tile.
// Define OFIFO_DRAIN_STALL_CNT_EN to add the stall_cycles counter port.
module ofifo_drain_ctrl #(
    parameter int COL    = 8,
    parameter int BW     = 4,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              ofifo_valid,
    output logic              ofifo_rd,
    input  logic [BW*COL-1:0] ofifo_data,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [BW*COL-1:0] sram_din,
    output logic              busy,
    output logic              done
`ifdef OFIFO_DRAIN_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int DW   = BW * COL;
    localparam int CD_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_WAIT, S_DONE} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   base_reg;
    logic [CNT_W-1:0]    num_reg;
    logic [CNT_W-1:0]    issued_reg;
    logic [CNT_W-1:0]    written_reg;
    logic [CD_W-1:0]     cd_reg;
    logic [RD_LAT-1:0]   pipe_reg;
    logic                ofifo_rd_reg;
    logic                sram_cen_reg;
    logic                sram_wen_reg;
    logic [ADDR_W-1:0]   sram_addr_reg;
    logic [DW-1:0]       sram_din_reg;
    logic                busy_reg;
    logic                done_reg;

    logic rd_ok;
    logic pipe_out;

    // cd_reg enforces the RD_LAT spacing so a stale o_valid cannot over-read.
    assign rd_ok    = ofifo_valid && (issued_reg < num_reg) && (cd_reg == '0);
    assign pipe_out = pipe_reg[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            num_reg       <= '0;
            issued_reg    <= '0;
            written_reg   <= '0;
            cd_reg        <= '0;
            pipe_reg      <= '0;
            ofifo_rd_reg  <= 1'b0;
            sram_cen_reg  <= 1'b1;
            sram_wen_reg  <= 1'b1;
            sram_addr_reg <= '0;
            sram_din_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            ofifo_rd_reg <= 1'b0;
            sram_cen_reg <= 1'b1;
            sram_wen_reg <= 1'b1;
            done_reg     <= 1'b0;

            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
            pipe_reg[0] <= ofifo_rd_reg;

            if (cd_reg != '0) begin
                cd_reg <= cd_reg - 1'b1;
            end

            // Pipe exit marks the cycle the FIFO row is valid on ofifo_data.
            if (pipe_out) begin
                sram_cen_reg  <= 1'b0;
                sram_wen_reg  <= 1'b0;
                sram_addr_reg <= base_reg + ADDR_W'(written_reg);
                sram_din_reg  <= ofifo_data;
                written_reg   <= written_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        base_reg    <= base_addr;
                        num_reg     <= num_words;
                        issued_reg  <= '0;
                        written_reg <= '0;
                        cd_reg      <= '0;
                        if (num_words != '0) begin
                            state_reg <= S_DRAIN;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (issued_reg == num_reg) begin
                        state_reg <= S_WAIT;
                    end else if (rd_ok) begin
                        ofifo_rd_reg <= 1'b1;
                        issued_reg   <= issued_reg + 1'b1;
                        cd_reg       <= CD_W'(RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (pipe_out && (written_reg == num_reg - 1'b1)) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ofifo_rd  = ofifo_rd_reg;
    assign sram_cen  = sram_cen_reg;
    assign sram_wen  = sram_wen_reg;
    assign sram_addr = sram_addr_reg;
    assign sram_din  = sram_din_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

`ifdef OFIFO_DRAIN_STALL_CNT_EN
    logic [31:0] stall_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            stall_reg <= '0;
        end else if (state_reg == S_DRAIN && issued_reg < num_reg && !ofifo_valid
                     && stall_reg != '1) begin
            stall_reg <= stall_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Directed bench for ofifo_drain_ctrl with a small RD_LAT=2 FIFO model and write log.
module tb_ofifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [10:0] num_words = '0;
    logic        ofifo_valid = 1'b1;
    logic        ofifo_rd;
    logic [31:0] ofifo_data = '0;
    logic        sram_cen;
    logic        sram_wen;
    logic [10:0] sram_addr;
    logic [31:0] sram_din;
    logic        busy;
    logic        done;
`ifdef OFIFO_DRAIN_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    ofifo_drain_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .ofifo_valid (ofifo_valid),
        .ofifo_rd    (ofifo_rd),
        .ofifo_data  (ofifo_data),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .busy        (busy),
        .done        (done)
`ifdef OFIFO_DRAIN_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;
    int e;
    int k0;
    int gap_lo = 0;
    int gap_hi = -1;

    function automatic logic [31:0] row_of(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0001_0103;
    endfunction

    // ofifo_valid drops for cycles gap_lo..gap_hi
    always @(negedge clk) ofifo_valid = !(cyc >= gap_lo && cyc <= gap_hi);

    // FIFO model: row k appears on ofifo_data two cycles after its rd
    logic        stage_v = 1'b0;
    logic [31:0] stage_d = '0;
    int          rd_total = 0;
    always @(posedge clk) begin
        if (ofifo_rd) begin
            stage_d  <= row_of(rd_total);
            rd_total <= rd_total + 1;
        end
        stage_v <= ofifo_rd;
        if (stage_v) ofifo_data <= stage_d;
    end

    int          rd_cyc[$];
    int          wr_cyc[$];
    logic [10:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cyc[$];
    int          busy_cnt = 0;
    int          cen_cnt = 0;

    always @(negedge clk) begin
        if (ofifo_rd) rd_cyc.push_back(cyc);
        if (!sram_cen && !sram_wen) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(sram_addr);
            wr_data.push_back(sram_din);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (!sram_cen) cen_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_cyc.delete();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        done_cyc.delete();
        busy_cnt = 0;
        cen_cnt  = 0;
        k0       = rd_total;
    endtask

    // returns e = first cycle in which the DUT is in its post-start state
    task automatic do_start(input logic [10:0] b, input logic [10:0] n, output int ent);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        ent       = cyc + 1;
        tick(1);
        start     = 1'b0;
        base_addr = 11'h555;
        num_words = 11'h007;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done_cyc.size() == 0 && n < limit) begin
            tick(1);
            n++;
        end
        tick(3);
        chk({tag, "_done_count"}, 32'(done_cyc.size()), 1);
    endtask

    task automatic chk_writes(input string tag, input int cnt, input logic [10:0] base,
                              input int first_cyc, input int spacing);
        logic [10:0] a;
        chk({tag, "_wr_count"}, 32'(wr_cyc.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < wr_cyc.size(); i++) begin
            a = base + 11'(i);
            chk($sformatf("%s_wr%0d_addr", tag, i), 32'(wr_addr[i]), 32'(a));
            chk($sformatf("%s_wr%0d_data", tag, i), wr_data[i], row_of(k0 + i));
            if (spacing > 0)
                chk($sformatf("%s_wr%0d_cyc", tag, i), 32'(wr_cyc[i]),
                    32'(first_cyc + spacing * i));
        end
    endtask

    initial begin
        tick(3);
        chk("rst_ofifo_rd", 32'(ofifo_rd), 0);
        chk("rst_sram_cen", 32'(sram_cen), 1);
        chk("rst_sram_wen", 32'(sram_wen), 1);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_sram_din", sram_din, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef OFIFO_DRAIN_STALL_CNT_EN
        chk("rst_stall", stall_cycles, 0);
`endif
        reset = 1'b0;
        tick(2);

        // T1: four words, valid always high
        clear_log();
        do_start(11'h010, 11'd4, e);
        wait_done("t1", 60);
        chk("t1_rd_count", 32'(rd_cyc.size()), 4);
        for (int i = 0; i < 4 && i < rd_cyc.size(); i++)
            chk($sformatf("t1_rd%0d_cyc", i), 32'(rd_cyc[i]), 32'(e + 1 + 2 * i));
        chk_writes("t1", 4, 11'h010, e + 4, 2);
        if (done_cyc.size() > 0) chk("t1_done_cyc", 32'(done_cyc[0]), 32'(e + 11));
        chk("t1_busy_cycles", 32'(busy_cnt), 10);
        chk("t1_addr_hold", 32'(sram_addr), 32'h013);
        chk("t1_cen_idle", 32'(sram_cen), 1);
        $display("T1 base=0x010 num=4 writes=%0d done_at=+%0d", wr_cyc.size(),
                 done_cyc.size() > 0 ? done_cyc[0] - e : -1);

        // T2: zero-length request
        clear_log();
        do_start(11'h020, 11'd0, e);
        wait_done("t2", 20);
        if (done_cyc.size() > 0) chk("t2_done_cyc", 32'(done_cyc[0]), 32'(e + 1));
        chk("t2_rd_count", 32'(rd_cyc.size()), 0);
        chk("t2_cen_count", 32'(cen_cnt), 0);
        chk("t2_busy_cycles", 32'(busy_cnt), 0);
        $display("T2 num=0 rd=%0d cen=%0d", rd_cyc.size(), cen_cnt);

        // T3: valid low for 5 cycles after the first rd
        clear_log();
        do_start(11'h040, 11'd3, e);
        gap_lo = e + 2;
        gap_hi = e + 6;
        wait_done("t3", 80);
        gap_lo = 0;
        gap_hi = -1;
        chk("t3_rd_count", 32'(rd_cyc.size()), 3);
        if (rd_cyc.size() == 3) begin
            chk("t3_rd0_cyc", 32'(rd_cyc[0]), 32'(e + 1));
            chk("t3_rd1_cyc", 32'(rd_cyc[1]), 32'(e + 8));
            chk("t3_rd2_cyc", 32'(rd_cyc[2]), 32'(e + 10));
        end
        chk_writes("t3", 3, 11'h040, 0, 0);
        if (done_cyc.size() > 0) chk("t3_done_cyc", 32'(done_cyc[0]), 32'(e + 14));
        chk("t3_busy_cycles", 32'(busy_cnt), 13);
`ifdef OFIFO_DRAIN_STALL_CNT_EN
        chk("t3_stall", stall_cycles, 5);
`endif
        $display("T3 num=3 gap=5 writes=%0d", wr_cyc.size());

        // T4: address wrap
        clear_log();
        do_start(11'h7FE, 11'd4, e);
        wait_done("t4", 60);
        chk_writes("t4", 4, 11'h7FE, e + 4, 2);
        $display("T4 base=0x7fe num=4 writes=%0d", wr_cyc.size());

        // T5: reset with one read in flight, then a fresh request
        clear_log();
        do_start(11'h300, 11'd4, e);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("t5_rst_cen", 32'(sram_cen), 1);
        chk("t5_rst_wen", 32'(sram_wen), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_rd", 32'(ofifo_rd), 0);
        chk("t5_rst_done", 32'(done), 0);
        reset = 1'b0;
        tick(6);
        chk("t5_rd_count", 32'(rd_cyc.size()), 1);
        chk("t5_no_write", 32'(wr_cyc.size()), 0);
        chk("t5_no_done", 32'(done_cyc.size()), 0);
        clear_log();
        do_start(11'h310, 11'd2, e);
        wait_done("t5b", 40);
        chk_writes("t5b", 2, 11'h310, e + 4, 2);
        if (done_cyc.size() > 0) chk("t5b_done_cyc", 32'(done_cyc[0]), 32'(e + 7));
        $display("T5 reset mid-drain, restart writes=%0d", wr_cyc.size());

        // T6: second start while busy is ignored
        clear_log();
        do_start(11'h100, 11'd2, e);
        tick(1);
        start     = 1'b1;
        base_addr = 11'h200;
        num_words = 11'd5;
        tick(1);
        start     = 1'b0;
        wait_done("t6", 60);
        chk("t6_rd_count", 32'(rd_cyc.size()), 2);
        chk_writes("t6", 2, 11'h100, e + 4, 2);
        if (done_cyc.size() > 0) chk("t6_done_cyc", 32'(done_cyc[0]), 32'(e + 7));
        $display("T6 base=0x100 num=2 with extra start, writes=%0d", wr_cyc.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
